// File: rtl/mem_port_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_master
// Description : Valid/ready request front-end for a single-port synchronous
//               memory. Registers one op per cycle onto the port, tracks reads
//               through a latency-matched tag pipeline, and queues read
//               responses in a credit-protected first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_master #(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_en,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic              o_busy
);

    localparam int                c_PTR_W = $clog2(RSP_DEPTH);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]  c_DEPTH = RSP_DEPTH[c_CNT_W:0];

    logic                  r_en;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [RD_LATENCY-1:0] r_tag_vld;
    logic [ADDR_W-1:0]     r_tag_addr [RD_LATENCY];
    logic [DATA_W-1:0]     r_fifo_data [RSP_DEPTH];
    logic [ADDR_W-1:0]     r_fifo_addr [RSP_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_CNT_W-1:0]    r_inflight;

    logic                  w_accept;
    logic                  w_rd_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [c_CNT_W:0]      w_used;

    // Every accepted read owns a FIFO slot from acceptance until it is popped.
    assign w_used      = {1'b0, r_count} + {1'b0, r_inflight};
    assign o_req_ready = !i_rst && (w_used < c_DEPTH);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_rd_accept = w_accept && !i_req_we;
    assign w_push      = r_tag_vld[RD_LATENCY-1];
    assign w_pop       = o_rsp_valid && i_rsp_ready;

    assign o_en        = r_en;
    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_rsp_valid = (r_count != '0);
    assign o_rsp_data  = o_rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign o_rsp_addr  = o_rsp_valid ? r_fifo_addr[r_rd_ptr] : '0;
    assign o_busy      = (r_inflight != '0) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_en <= w_accept;
            r_we <= w_accept && i_req_we;
            if (w_accept) begin
                r_addr  <= i_req_addr;
                r_wdata <= i_req_data;
            end
        end
    end

    // Stage k holds a read issued k+1 cycles ago; the last stage lines up with i_rdata.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_tag_vld[k]  <= 1'b0;
                r_tag_addr[k] <= '0;
            end
        end else begin
            r_tag_vld[0]  <= r_en && !r_we;
            r_tag_addr[0] <= r_addr;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_tag_vld[k]  <= r_tag_vld[k-1];
                r_tag_addr[k] <= r_tag_addr[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= i_rdata;
            r_fifo_addr[r_wr_ptr] <= r_tag_addr[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_rd_accept, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_master
// Description : Directed self-checking bench for mem_port_master with
//               RD_LATENCY=1 and RD_LATENCY=3 instances on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [11:0] req_data;
    logic        rsp_ready;

    logic        ready1, en1, we1, rsp_valid1, busy1;
    logic [7:0]  addr1, rsp_addr1;
    logic [11:0] wdata1, rdata1, rsp_data1;

    logic        ready3, en3, we3, rsp_valid3, busy3;
    logic [7:0]  addr3, rsp_addr3;
    logic [11:0] wdata3, rdata3, rsp_data3;
    logic [11:0] d3a, d3b, d3c;

    mem_port_master #(.DATA_W(12), .ADDR_W(8), .RD_LATENCY(1), .RSP_DEPTH(4)) u_dut1 (
        .clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready1),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_en(en1), .o_we(we1), .o_addr(addr1), .o_wdata(wdata1), .i_rdata(rdata1),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data1),
        .o_rsp_addr(rsp_addr1), .o_busy(busy1)
    );

    mem_port_master #(.DATA_W(12), .ADDR_W(8), .RD_LATENCY(3), .RSP_DEPTH(4)) u_dut3 (
        .clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready3),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_en(en3), .o_we(we3), .o_addr(addr3), .o_wdata(wdata3), .i_rdata(rdata3),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data3),
        .o_rsp_addr(rsp_addr3), .o_busy(busy3)
    );

    function automatic logic [11:0] init_val(input logic [7:0] a);
        return 12'h300 ^ {a[3:0], a};
    endfunction

    // Memory models: contents reload on reset, reads return data RD_LATENCY cycles later.
    logic [11:0] mem1 [256];
    logic [11:0] mem3 [256];
    assign rdata3 = d3c;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= init_val(8'(i));
                mem3[i] <= init_val(8'(i));
            end
        end else begin
            if (en1 && we1) mem1[addr1] <= wdata1;
            if (en3 && we3) mem3[addr3] <= wdata3;
        end
        if (en1 && !we1) rdata1 <= mem1[addr1];
        if (en3 && !we3) d3a <= mem3[addr3];
        d3b <= d3a;
        d3c <= d3b;
    end

    int          n_total = 0;
    int          n_bad   = 0;
    logic [11:0] ref_mem [256];
    logic [7:0]  q_addr [$];
    logic [11:0] q_data [$];
    logic        got_rdy;
    int          acc;
    logic        exp_v;

    task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        q_addr.delete();
        q_data.delete();
    endtask

    // One cycle against the reference: queue holds every accepted, unpopped read.
    task automatic model_step(input logic v, input logic we, input logic [7:0] a,
                              input logic [11:0] d, input logic rr);
        req_valid = v; req_we = we; req_addr = a; req_data = d; rsp_ready = rr;
        chk_value("mdl_ready", 32'(ready1), 32'(q_addr.size() < 4));
        if (rsp_valid1 && rr) begin
            if (q_addr.size() == 0) begin
                chk_value("mdl_extra_rsp", 32'(rsp_valid1), 32'd0);
            end else begin
                chk_value("mdl_rsp_addr", 32'(rsp_addr1), 32'(q_addr[0]));
                chk_value("mdl_rsp_data", 32'(rsp_data1), 32'(q_data[0]));
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
        end
        if (v && ready1) begin
            if (we) begin
                ref_mem[a] = d;
            end else begin
                q_addr.push_back(a);
                q_data.push_back(ref_mem[a]);
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        tick();
        tick();
        chk_value("rst_ready", 32'(ready1), 32'd0);
        chk_value("rst_en", 32'(en1), 32'd0);
        chk_value("rst_we", 32'(we1), 32'd0);
        chk_value("rst_addr", 32'(addr1), 32'd0);
        chk_value("rst_wdata", 32'(wdata1), 32'd0);
        chk_value("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk_value("rst_rsp_data", 32'(rsp_data1), 32'd0);
        chk_value("rst_rsp_addr", 32'(rsp_addr1), 32'd0);
        chk_value("rst_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        #1;
        chk_value("ready_after_rst", 32'(ready1), 32'd1);

        // Write 0x05 <= 0xABC, then read it back
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_data = 12'hABC;
        tick();
        chk_value("wr_en", 32'(en1), 32'd1);
        chk_value("wr_we", 32'(we1), 32'd1);
        chk_value("wr_addr", 32'(addr1), 32'h05);
        chk_value("wr_wdata", 32'(wdata1), 32'hABC);
        req_we = 1'b0;
        tick();
        chk_value("rd_en", 32'(en1), 32'd1);
        chk_value("rd_we", 32'(we1), 32'd0);
        chk_value("rd_addr", 32'(addr1), 32'h05);
        req_valid = 1'b0;
        tick();
        chk_value("rd_en_pulse", 32'(en1), 32'd0);
        chk_value("rd_valid_early", 32'(rsp_valid1), 32'd0);
        chk_value("rd_busy", 32'(busy1), 32'd1);
        tick();
        chk_value("rd_valid", 32'(rsp_valid1), 32'd1);
        chk_value("rd_data", 32'(rsp_data1), 32'hABC);
        chk_value("rd_rsp_addr", 32'(rsp_addr1), 32'h05);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_value("rd_popped", 32'(rsp_valid1), 32'd0);
        chk_value("rd_idle", 32'(busy1), 32'd0);

        // Credit limit: continuous reads with consumer stalled
        do_reset();
        req_valid = 1'b1; req_we = 1'b0; acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 8'h20 + 8'(acc);
            got_rdy = ready1;
            tick();
            if (got_rdy) acc++;
        end
        req_valid = 1'b0;
        chk_value("fill_accepts", 32'(acc), 32'd4);
        chk_value("fill_ready_low", 32'(ready1), 32'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_value($sformatf("drain_valid%0d", k), 32'(rsp_valid1), 32'd1);
            chk_value($sformatf("drain_addr%0d", k), 32'(rsp_addr1), 32'(8'h20 + 8'(k)));
            chk_value($sformatf("drain_data%0d", k), 32'(rsp_data1), 32'(init_val(8'h20 + 8'(k))));
            if (k == 0) chk_value("drain_ready_before_pop", 32'(ready1), 32'd0);
            if (k == 1) chk_value("drain_ready_after_pop", 32'(ready1), 32'd1);
            tick();
        end
        rsp_ready = 1'b0;
        chk_value("drain_empty", 32'(rsp_valid1), 32'd0);

        // RD_LATENCY=3 back-to-back reads
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10 + 8'(c);
                chk_value($sformatf("lat3_ready%0d", c), 32'(ready3), 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            exp_v = (c >= 5 && c <= 8);
            chk_value($sformatf("lat3_valid%0d", c), 32'(rsp_valid3), 32'(exp_v));
            if (exp_v) begin
                chk_value($sformatf("lat3_addr%0d", c), 32'(rsp_addr3), 32'(8'h10 + 8'(c - 5)));
                chk_value($sformatf("lat3_data%0d", c), 32'(rsp_data3), 32'(init_val(8'h10 + 8'(c - 5))));
            end
            tick();
        end

        // Random mix against the reference queue, starting from a full credit window
        do_reset();
        for (int i = 0; i < 6; i++) model_step(1'b1, 1'b0, 8'h40 + 8'(i), 12'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            model_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                       8'h40 + 8'($urandom_range(0, 63)), 12'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 10; i++) model_step(1'b0, 1'b0, 8'h00, 12'h0, 1'b1);
        chk_value("mdl_all_returned", 32'(q_addr.size()), 32'd0);
        chk_value("mdl_final_valid", 32'(rsp_valid1), 32'd0);
        chk_value("mdl_final_busy", 32'(busy1), 32'd0);

        // Reset with 2 reads in FIFO and 2 in flight
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h50 + 8'(i);
            tick();
        end
        req_valid = 1'b0;
        chk_value("mid_busy", 32'(busy1), 32'd1);
        chk_value("mid_valid", 32'(rsp_valid1), 32'd1);
        rst = 1'b1;
        tick();
        chk_value("mid_rst_ready", 32'(ready1), 32'd0);
        chk_value("mid_rst_en", 32'(en1), 32'd0);
        chk_value("mid_rst_we", 32'(we1), 32'd0);
        chk_value("mid_rst_addr", 32'(addr1), 32'd0);
        chk_value("mid_rst_wdata", 32'(wdata1), 32'd0);
        chk_value("mid_rst_valid", 32'(rsp_valid1), 32'd0);
        chk_value("mid_rst_data", 32'(rsp_data1), 32'd0);
        chk_value("mid_rst_rsp_addr", 32'(rsp_addr1), 32'd0);
        chk_value("mid_rst_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_value($sformatf("post_rst_valid%0d", i), 32'(rsp_valid1), 32'd0);
            tick();
        end

        // Writes only, consumer stalled
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h80 + 8'(i); req_data = 12'h600 + 12'(i);
            chk_value($sformatf("wo_ready%0d", i), 32'(ready1), 32'd1);
            chk_value($sformatf("wo_valid%0d", i), 32'(rsp_valid1), 32'd0);
            if (i > 0) chk_value($sformatf("wo_we%0d", i), 32'({en1, we1}), 32'd3);
            tick();
        end
        req_valid = 1'b0;
        tick();
        tick();
        chk_value("wo_valid_end", 32'(rsp_valid1), 32'd0);
        chk_value("wo_busy_end", 32'(busy1), 32'd0);
        chk_value("wo_en_end", 32'(en1), 32'd0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h83;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk_value("wo_readback", 32'(rsp_data1), 32'h603);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 Parameter DATA_W, default 12: width of write and read data words.
REQ-002 Parameter ADDR_W, default 8: width of memory address; matches one memory port address.
REQ-003 Parameter RD_LATENCY, default 1: memory read latency in cycles, legal range 1..4.
REQ-004 Parameter RSP_DEPTH, default 4: response FIFO depth, power of two, legal range 2..16.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  synchronous, active-high reset.
REQ-007 i_req_valid  input  1  request present.
REQ-008 o_req_ready  output  1  request accepted this cycle when high with i_req_valid.
REQ-009 i_req_we  input  1  1 = write, 0 = read.
REQ-010 i_req_addr  input  ADDR_W  request address.
REQ-011 i_req_data  input  DATA_W  write data; ignored for reads.
REQ-012 o_en  output  1  memory port enable.
REQ-013 o_we  output  1  memory port write enable.
REQ-014 o_addr  output  ADDR_W  memory port address.
REQ-015 o_wdata  output  DATA_W  memory port write data.
REQ-016 i_rdata  input  DATA_W  memory port read data.
REQ-017 o_rsp_valid  output  1  read response available.
REQ-018 i_rsp_ready  input  1  consumer takes response when high with o_rsp_valid.
REQ-019 o_rsp_data  output  DATA_W  read data of head response.
REQ-020 o_rsp_addr  output  ADDR_W  address that produced head response.
REQ-021 o_busy  output  1  high while any read is in flight or FIFO non-empty.

Function
REQ-022 Acceptance (valid & ready, cycle A) SHALL register the request onto o_en/o_we/o_addr/o_wdata in cycle A+1; o_en is a one-cycle pulse per request; o_en=0, o_we=0 when no request accepted in previous cycle; o_addr/o_wdata hold last value.
REQ-023 Back-to-back acceptance SHALL be allowed every cycle (one memory op per cycle max).
REQ-024 For a read issued (o_en=1, o_we=0) in cycle T, i_rdata SHALL be sampled at the end of cycle T+RD_LATENCY and pushed into the response FIFO with its address, via an RD_LATENCY-deep valid/address tag pipeline.
REQ-025 Read latency accept->o_rsp_valid SHALL be exactly RD_LATENCY+2 cycles when FIFO empty (RD_LATENCY=1: accept cycle 0, o_en cycle 1, i_rdata cycle 2, o_rsp_valid cycle 3).
REQ-026 Writes SHALL produce no response and consume no FIFO credit.
REQ-027 Credit rule: inflight = reads accepted but not yet pushed; o_req_ready = !i_rst & (fifo_count + inflight < RSP_DEPTH); FIFO SHALL never overflow.
REQ-028 o_req_ready SHALL be combinational from registered state only (no dependency on i_req_valid or i_req_we).
REQ-029 FIFO SHALL be first-word fall-through; o_rsp_valid = (fifo_count != 0); no same-cycle bypass from push to output.
REQ-030 Simultaneous push and pop SHALL leave fifo_count unchanged; pop when full frees credit visible on o_req_ready next cycle.
REQ-031 Read pointers/write pointers SHALL wrap modulo RSP_DEPTH; fifo_count width clog2(RSP_DEPTH)+1.
REQ-032 Responses SHALL emerge in issue order.
REQ-033 o_rsp_data/o_rsp_addr SHALL be stable while o_rsp_valid & !i_rsp_ready.

Reset
REQ-034 During i_rst: o_req_ready=0, o_en=0, o_we=0, o_addr=0, o_wdata=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_addr=0, o_busy=0 from the cycle after reset asserts.
REQ-035 Reset mid-operation SHALL discard all in-flight reads and FIFO contents; no response after reset from pre-reset requests.
REQ-036 First request SHALL be accepted in the first cycle after i_rst deasserts.

Verification
REQ-037 RD_LATENCY=1: write addr 0x05 data 0xABC, then read 0x05 -> o_en pulses with o_we=1 then o_we=0; o_rsp_valid 3 cycles after read accept, o_rsp_data=0xABC, o_rsp_addr=0x05.
REQ-038 RSP_DEPTH=4, i_rsp_ready=0, continuous reads -> exactly 4 accepted, o_req_ready low thereafter; raise i_rsp_ready -> 4 responses in order, ready reasserts one cycle after first pop.
REQ-039 RD_LATENCY=3, back-to-back reads of 0x10..0x13 -> o_rsp_valid 5 cycles after first accept, then one response per cycle, addresses 0x10..0x13.
REQ-040 FIFO full with i_rsp_ready=1 and push same cycle -> count constant, no data loss, order preserved over 20 random ops vs. reference model.
REQ-041 Assert i_rst with 2 reads in flight and 2 in FIFO -> next cycle all outputs 0, no responses appear for 10 cycles.
REQ-042 Writes only, i_rsp_ready=0, 8 consecutive writes -> all accepted every cycle, o_rsp_valid stays 0.
